// File: rtl/trdb_pkg.sv
// ---------------------------------------------------------------------------
// trdb_pkg
// Shared definitions for the trace debugger branch-map path. The encoder-side
// branch recorder and the reconstruction-side unmapper both use the packed
// branch-map word defined here, so its layout must stay in lockstep.
// ---------------------------------------------------------------------------
package trdb_pkg;

    // Map capacity in branches; fixed by the packet format.
    localparam int BRANCH_MAP_LEN = 31;
    // Width of branch counts and indices (0..31).
    localparam int BRANCH_CNT_W   = 5;

    // One packed branch map: bit k is branch k, 1 = not taken, 0 = taken.
    typedef struct packed {
        logic [BRANCH_MAP_LEN-1:0] map;
        logic [BRANCH_CNT_W-1:0]   cnt;
    } trdb_bmap_t;

endpackage : trdb_pkg

// File: rtl/trdb_branch_unmap.sv
// ---------------------------------------------------------------------------
// trdb_branch_unmap
// Replays packed branch maps one outcome per query. Two slots (active and
// pending) let the packet parser deliver the next map while the current one
// drains; the switch from pending to active costs no idle cycle.
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   flush_i         drop all buffered maps (overrides same-cycle load/query)
//   load_valid_i    a {map, count} word is offered
//   load_ready_o    the offered word is accepted this cycle
//   map_i           packed outcomes, bit k = branch k, 1 = not taken
//   branches_i      number of valid bits in map_i (0 = accept and drop)
//   query_valid_i   walker requests the next outcome
//   query_ready_o   an outcome is available
//   branch_taken_o  outcome of the current query
//   remaining_o     outcomes left in the active slot
//   empty_o         both slots empty
//   underrun_o      one-cycle pulse: a query found no outcome
// ---------------------------------------------------------------------------
module trdb_branch_unmap
    import trdb_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [BRANCH_MAP_LEN-1:0] map_i,
    input  logic [BRANCH_CNT_W-1:0]   branches_i,
    input  logic                      query_valid_i,
    output logic                      query_ready_o,
    output logic                      branch_taken_o,
    output logic [BRANCH_CNT_W-1:0]   remaining_o,
    output logic                      empty_o,
    output logic                      underrun_o
);

    // Slot state
    logic                    r_act_valid, r_act_valid_next;
    trdb_bmap_t              r_act_bm,    r_act_bm_next;
    logic [BRANCH_CNT_W-1:0] r_act_idx,   r_act_idx_next;
    logic                    r_pnd_valid, r_pnd_valid_next;
    trdb_bmap_t              r_pnd_bm,    r_pnd_bm_next;
    logic                    r_underrun,  r_underrun_next;

    // Handshake decode
    logic       w_load_ready;
    logic       w_load_keep;
    logic       w_query_xfer;
    logic       w_last;
    logic       w_act_free;
    trdb_bmap_t w_in_bm;

    assign w_in_bm      = '{map: map_i, cnt: branches_i};

    // Ready depends only on registers and flush, never on the valids.
    assign w_load_ready = ~r_pnd_valid & ~flush_i;
    // Zero-length words complete the handshake but carry nothing.
    assign w_load_keep  = load_valid_i & w_load_ready & (branches_i != '0);
    assign w_query_xfer = query_valid_i & r_act_valid & ~flush_i;
    assign w_last       = w_query_xfer & ((r_act_idx + 5'd1) == r_act_bm.cnt);
    // Active slot can take a new word on this edge: it is empty now, or it
    // is being drained and nothing is waiting in pending to replace it.
    assign w_act_free   = ~r_act_valid | (w_last & ~r_pnd_valid);

    always_comb begin
        r_act_valid_next = r_act_valid;
        r_act_bm_next    = r_act_bm;
        r_act_idx_next   = r_act_idx;
        r_pnd_valid_next = r_pnd_valid;
        r_pnd_bm_next    = r_pnd_bm;
        r_underrun_next  = 1'b0;

        if (flush_i) begin
            r_act_valid_next = 1'b0;
            r_pnd_valid_next = 1'b0;
            r_act_idx_next   = '0;
        end else begin
            r_underrun_next = query_valid_i & ~r_act_valid;

            // Consume side
            if (w_last) begin
                r_act_idx_next = '0;
                if (r_pnd_valid) begin
                    r_act_bm_next    = r_pnd_bm;
                    r_pnd_valid_next = 1'b0;
                end else begin
                    r_act_valid_next = 1'b0;
                end
            end else if (w_query_xfer) begin
                r_act_idx_next = r_act_idx + 5'd1;
            end

            // Load side; pending is free whenever a load is accepted, so the
            // two sides never fight over the same slot.
            if (w_load_keep) begin
                if (w_act_free) begin
                    r_act_valid_next = 1'b1;
                    r_act_bm_next    = w_in_bm;
                    r_act_idx_next   = '0;
                end else begin
                    r_pnd_valid_next = 1'b1;
                    r_pnd_bm_next    = w_in_bm;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_act_valid <= 1'b0;
            r_act_bm    <= '0;
            r_act_idx   <= '0;
            r_pnd_valid <= 1'b0;
            r_pnd_bm    <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_act_valid <= r_act_valid_next;
            r_act_bm    <= r_act_bm_next;
            r_act_idx   <= r_act_idx_next;
            r_pnd_valid <= r_pnd_valid_next;
            r_pnd_bm    <= r_pnd_bm_next;
            r_underrun  <= r_underrun_next;
        end
    end

    assign load_ready_o   = w_load_ready;
    assign query_ready_o  = r_act_valid;
    // Index stays below cnt (at most 30), so bit 31 is never selected.
    assign branch_taken_o = ~r_act_bm.map[r_act_idx];
    assign remaining_o    = r_act_valid ? (r_act_bm.cnt - r_act_idx) : '0;
    assign empty_o        = ~r_act_valid & ~r_pnd_valid;
    assign underrun_o     = r_underrun;

endmodule : trdb_branch_unmap
